// File: rtl/mul_issue_pkg.sv
// Shared types and the round-robin pick helper for the multiplier issue arbiter and
// the CDB arbiter that reuses it.
package mul_issue_pkg;

  localparam int unsigned N_REQ_DEF             = 4;
  localparam int unsigned BW_PROCESSOR_DATA_DEF = 32;
  localparam int unsigned BW_TAG_DEF            = 1;
  localparam int unsigned BW_GRANT              = $clog2(N_REQ_DEF);

  // Widest requester vector the pick helper handles.
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned IDX_W   = 5;

  typedef struct packed {
    logic [BW_TAG_DEF-1:0]                  tag;
    logic [1:0][BW_PROCESSOR_DATA_DEF-1:0] v;
  } mul_op_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First valid index scanning ptr, ptr+1 .. ptr+n-1 (mod n).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        n);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        k = 32'(ptr) + i;
        if (k >= n) k = k - n;
        if (!r.found && valid[k[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = k[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_issue_arbiter_if.sv
// Issue-side bundle: RS requester handshakes in, one held op out to the multiplier.
interface mul_issue_arbiter_if #(
  parameter int unsigned N_REQ             = 4,
  parameter int unsigned BW_PROCESSOR_DATA = 32,
  parameter int unsigned BW_TAG            = 1
);
  localparam int unsigned SEL_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                     req_valid;
  logic [N_REQ-1:0]                     req_ready;
  logic [N_REQ*BW_TAG-1:0]              req_tag;
  logic [N_REQ*2*BW_PROCESSOR_DATA-1:0] req_v;
  logic                                 mul_valid;
  logic                                 mul_ready;
  logic [BW_TAG-1:0]                    mul_tag;
  logic [2*BW_PROCESSOR_DATA-1:0]       mul_v;
  logic [SEL_W-1:0]                     grant_id;

  // Requesters plus the multiplier side.
  modport master (
    output req_valid, req_tag, req_v, mul_ready,
    input  req_ready, mul_valid, mul_tag, mul_v, grant_id
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_tag, req_v, mul_ready,
    output req_ready, mul_valid, mul_tag, mul_v, grant_id
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first valid requester at or after ptr.
module rr_picker
  import mul_issue_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] sel,
  output logic             any_valid
);

  rr_pick_t pick;

  always_comb begin
    pick      = rr_pick(MAX_REQ'(valid), IDX_W'(ptr), N_REQ);
    sel       = SEL_W'(pick.idx);
    any_valid = pick.found;
  end

endmodule

// File: rtl/mul_issue_arbiter.sv
// Round-robin issue of one RS operand pair per cycle into a single held output register
// that drives the multiplier's valid/ready port.
module mul_issue_arbiter
  import mul_issue_pkg::*;
#(
  parameter int unsigned N_REQ             = N_REQ_DEF,
  parameter int unsigned BW_PROCESSOR_DATA = BW_PROCESSOR_DATA_DEF,
  parameter int unsigned BW_TAG            = BW_TAG_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mul_issue_arbiter_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(N_REQ);
  localparam int unsigned VW    = 2 * BW_PROCESSOR_DATA;

  logic [SEL_W-1:0]  ptr_q, ptr_d, sel, grant_q;
  logic              valid_q, load, any_valid, cen;
  logic [BW_TAG-1:0] tag_q;
  logic [VW-1:0]     v_q;
  logic [N_REQ-1:0]  ready;

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .valid    (bus.req_valid),
    .ptr      (ptr_q),
    .sel      (sel),
    .any_valid(any_valid)
  );

  // The register may reload in the same cycle the multiplier takes the old op.
  always_comb begin
    load       = !valid_q || bus.mul_ready;
    cen        = load && any_valid && rst_n;
    ready      = '0;
    if (cen) ready[sel] = 1'b1;
    ptr_d      = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      v_q     <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (load) valid_q <= any_valid;
      if (cen) begin
        tag_q   <= bus.req_tag[int'(sel) * BW_TAG +: BW_TAG];
        v_q     <= bus.req_v[int'(sel) * VW +: VW];
        grant_q <= sel;
        ptr_q   <= ptr_d;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.mul_valid = valid_q;
  assign bus.mul_tag   = tag_q;
  assign bus.mul_v     = v_q;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Directed bench for mul_issue_arbiter (N_REQ=4, BW_TAG=2) with an issue scoreboard.
module tb_mul_issue_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_issue_arbiter_if #(.N_REQ(4), .BW_PROCESSOR_DATA(32), .BW_TAG(2)) bus ();

  mul_issue_arbiter #(
    .N_REQ            (4),
    .BW_PROCESSOR_DATA(32),
    .BW_TAG           (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [1:0]  tb_tag [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] tb_v0  [4] = '{32'h11, 32'h22, 32'h7, 32'h44};
  logic [31:0] tb_v1  [4] = '{32'h1000_0000, 32'h2000_0000, 32'hFFFF_FFFA, 32'h4000_0000};

  int n_total = 0;
  int n_bad   = 0;
  logic [65:0] sbq[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input string t, input int gid);
    check({t, "_vld"}, 128'(bus.mul_valid), 128'(1'b1));
    check({t, "_gid"}, 128'(bus.grant_id), 128'(gid));
    check({t, "_tag"}, 128'(bus.mul_tag), 128'(tb_tag[gid]));
    check({t, "_v"}, 128'(bus.mul_v), 128'({tb_v1[gid], tb_v0[gid]}));
  endtask

  // Every accepted op must reach the multiplier port exactly once, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (bus.mul_valid && bus.mul_ready) begin
        if (sbq.size() == 0) check("sb_extra_issue", 128'(1), 128'(0));
        else check("sb_op", 128'({bus.mul_tag, bus.mul_v}), 128'(sbq.pop_front()));
      end
      for (int k = 0; k < 4; k++)
        if (bus.req_valid[k] && bus.req_ready[k])
          sbq.push_back({tb_tag[k], tb_v1[k], tb_v0[k]});
    end
  end

  int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    for (int k = 0; k < 4; k++) begin
      bus.req_tag[k*2 +: 2] = tb_tag[k];
      bus.req_v[k*64 +: 64] = {tb_v1[k], tb_v0[k]};
    end
    rst_n         = 1'b0;
    bus.req_valid = 4'hf;
    bus.mul_ready = 1'b0;
    tick();
    tick();
    check("rst_ready", 128'(bus.req_ready), 128'(0));
    check("rst_vld", 128'(bus.mul_valid), 128'(0));
    check("rst_tag", 128'(bus.mul_tag), 128'(0));
    check("rst_v", 128'(bus.mul_v), 128'(0));
    check("rst_gid", 128'(bus.grant_id), 128'(0));

    // 1: reset drops a held op; ptr returns to 0
    rst_n = 1'b1; bus.req_valid = 4'b0010; bus.mul_ready = 1'b0;
    #1 check("t1_ready", 128'(bus.req_ready), 128'(4'b0010));
    tick();
    expect_op("t1_held", 1);
    bus.req_valid = 4'b0000;
    tick();
    expect_op("t1_stall", 1);
    rst_n = 1'b0;
    tick();
    check("t1_rst_vld", 128'(bus.mul_valid), 128'(0));
    check("t1_rst_tag", 128'(bus.mul_tag), 128'(0));
    check("t1_rst_v", 128'(bus.mul_v), 128'(0));
    check("t1_rst_gid", 128'(bus.grant_id), 128'(0));
    rst_n = 1'b1; bus.req_valid = 4'b1111; bus.mul_ready = 1'b1;
    #1 check("t1_post_ready", 128'(bus.req_ready), 128'(4'b0001));
    tick();
    expect_op("t1_post", 0);                    // ptr=1

    // 2: single request from req2
    bus.req_valid = 4'b0100;
    #1 check("t2_ready", 128'(bus.req_ready), 128'(4'b0100));
    tick();
    check("t2_vld", 128'(bus.mul_valid), 128'(1));
    check("t2_tag", 128'(bus.mul_tag), 128'(2'd3));
    check("t2_v", 128'(bus.mul_v), 128'({32'hFFFF_FFFA, 32'h0000_0007}));
    check("t2_gid", 128'(bus.grant_id), 128'(2));  // ptr=3

    // 3: bring ptr to 0, then all valid for 8 back-to-back cycles
    bus.req_valid = 4'b1000;
    tick();
    expect_op("t3_pre", 3);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 check("t3_ready", 128'(bus.req_ready), 128'(4'b0001 << exp_seq[i]));
      tick();
      expect_op("t3_grant", exp_seq[i]);
    end

    // 4: backpressure with req1 and req3 pending
    bus.req_valid = 4'b1010;
    #1 check("t4_ready", 128'(bus.req_ready), 128'(4'b0010));
    tick();
    expect_op("t4_first", 1);                   // ptr=2
    bus.mul_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("t4_bp_ready", 128'(bus.req_ready), 128'(0));
      tick();
      expect_op("t4_bp_hold", 1);
    end
    bus.mul_ready = 1'b1;
    #1 check("t4_rel_ready", 128'(bus.req_ready), 128'(4'b1000));
    tick();
    expect_op("t4_rel", 3);                     // ptr=0

    // 5: wrap from ptr=3 with req0 and req3 valid
    bus.req_valid = 4'b0100;
    tick();
    expect_op("t5_pre", 2);                     // ptr=3
    bus.req_valid = 4'b1001;
    #1 check("t5_ready_a", 128'(bus.req_ready), 128'(4'b1000));
    tick();
    expect_op("t5_a", 3);
    check("t5_ready_b", 128'(bus.req_ready), 128'(4'b0001));
    tick();
    expect_op("t5_b", 0);                       // ptr=1

    // 6: drain with no requests; data and ptr hold
    bus.req_valid = 4'b0000;
    #1 check("t6_ready", 128'(bus.req_ready), 128'(0));
    tick();
    check("t6_vld", 128'(bus.mul_valid), 128'(0));
    check("t6_gid_hold", 128'(bus.grant_id), 128'(0));
    check("t6_tag_hold", 128'(bus.mul_tag), 128'(tb_tag[0]));
    tick();
    check("t6_vld_idle", 128'(bus.mul_valid), 128'(0));
    bus.req_valid = 4'b1111;
    #1 check("t6_ptr_ready", 128'(bus.req_ready), 128'(4'b0010));
    tick();
    expect_op("t6_ptr", 1);
    bus.req_valid = 4'b0000;
    tick();
    check("t6_end_vld", 128'(bus.mul_valid), 128'(0));
    tick();
    check("sb_empty", 128'(sbq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
